fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction decoder. It holds the program counter and drives a synchronous-read instruction memory. It latches each returned word into an instruction register that feeds the decoder's instruction input. It advances or redirects the PC when the downstream execute/control logic acknowledges the current instruction, using a multicycle FSM with one instruction in flight.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Holds the program counter, drives a
//             synchronous-read instruction memory, and latches the returned
//             word into an instruction register for the decoder. One
//             instruction is in flight at a time, under a four-state FSM:
//             IDLE -> FETCH -> WAIT -> ISSUE -> FETCH ...
//  Ports    :
//    clk, rst_n          clock (rising edge), async active-low reset
//    mem_addr            instruction memory address (= pc)
//    mem_rd_en           memory read strobe
//    mem_rdata           memory read data, valid the cycle after mem_rd_en
//    stall               holds off a new fetch while in FETCH
//    instr_out           instruction register, to the decoder
//    instr_valid         instr_out holds an instruction awaiting execution
//    instr_ack           downstream finished the current instruction
//    redirect            take redirect_target as next PC (with instr_ack)
//    redirect_target     absolute next PC on a redirect
//    pc_out, pc_plus1    PC of instr_out and its successor (JAL link)
//    retired_count       number of acknowledged instructions (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus1,
  output logic [15:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_WAIT  = 2'b10,
    S_ISSUE = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    mem_rd_en   = 1'b0;
    instr_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (!stall) begin
          mem_rd_en = 1'b1;
          state_d   = S_WAIT;
        end
      end

      // Read data returns this cycle; stall has no effect on a read
      // that has already been issued.
      S_WAIT: begin
        instr_d = mem_rdata;
        state_d = S_ISSUE;
      end

      // stall is deliberately not consulted here: it only delays the
      // following FETCH, never the acknowledge itself.
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          pc_d      = redirect ? redirect_target : pc_q + 16'd1;
          retired_d = retired_q + 16'd1;
          instr_d   = NOP_INSTR;
          state_d   = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr      = pc_q;
  assign pc_out        = pc_q;
  assign pc_plus1      = pc_q + 16'd1;
  assign instr_out     = instr_q;
  assign retired_count = retired_q;

endmodule
`default_nettype wire
